ps2_rx_frame: RTL and testbench

Receives PS/2 keyboard frames from the raw ps2_clk/ps2_data lines and produces a validated 8-bit scan code. It sits directly upstream of the seven-segment controller and drives that block's 8-bit data input. It synchronises and glitch-filters the PS/2 clock, deframes the 11-bit frame (start, 8 data bits LSB first, odd parity, stop), and holds the last good byte on its output.

---
 rtl/ps2_rx_frame.sv | 200 ++++++++++++++++++++
 tb/tb_ps2_rx_frame.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/ps2_rx_frame.sv
// PS/2 receive front end: synchronises and glitch-filters the raw PS/2 lines,
// deframes 11-bit frames and holds the last good scan code for the display path.
module ps2_rx_frame #(
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] data,
    output logic       data_valid,
    output logic       parity_err,
    output logic       frame_err,
    output logic       busy
);

    localparam int FW = $clog2(FILTER_LEN);
    localparam int TW = $clog2(TIMEOUT_CYCLES);
    localparam logic [FW-1:0] FLT_LAST = FW'(FILTER_LEN - 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DATA   = 2'd1,
        ST_PARITY = 2'd2,
        ST_STOP   = 2'd3
    } state_t;

    // Odd parity over the data byte plus the parity bit.
    function automatic logic odd_parity_ok(input logic [7:0] b, input logic p);
        return ((^b) ^ p) == 1'b1;
    endfunction

    logic          clk_s1_q, clk_s1_d, clk_s2_q, clk_s2_d;
    logic          dat_s1_q, dat_s1_d, dat_s2_q, dat_s2_d;
    logic          clk_f_q, clk_f_d;
    logic [FW-1:0] flt_cnt_q, flt_cnt_d;
    logic          fall_tick_q, fall_tick_d;

    state_t        state_q, state_d;
    logic [2:0]    bit_cnt_q, bit_cnt_d;
    logic [7:0]    shift_q, shift_d;
    logic          par_q, par_d;
    logic [TW-1:0] wdog_q, wdog_d;
    logic [7:0]    data_q, data_d;
    logic          data_valid_q, data_valid_d;
    logic          parity_err_q, parity_err_d;
    logic          frame_err_q, frame_err_d;
    logic          busy_q, busy_d;

    // Synchronisers, level filter and falling-edge detect of the filtered clock.
    always_comb begin
        clk_s1_d  = ps2_clk;
        clk_s2_d  = clk_s1_q;
        dat_s1_d  = ps2_data;
        dat_s2_d  = dat_s1_q;
        clk_f_d   = clk_f_q;
        flt_cnt_d = FW'(0);
        if (clk_s2_q != clk_f_q) begin
            if (flt_cnt_q == FLT_LAST) begin
                clk_f_d   = clk_s2_q;
                flt_cnt_d = FW'(0);
            end else begin
                flt_cnt_d = flt_cnt_q + FW'(1);
            end
        end else begin
            flt_cnt_d = FW'(0);
        end
        fall_tick_d = clk_f_q & ~clk_f_d;
    end

    // Frame sequencing, watchdog and registered result pulses.
    always_comb begin
        state_d      = state_q;
        bit_cnt_d    = bit_cnt_q;
        shift_d      = shift_q;
        par_d        = par_q;
        data_d       = data_q;
        data_valid_d = 1'b0;
        parity_err_d = 1'b0;
        frame_err_d  = 1'b0;

        if ((state_q == ST_IDLE) || fall_tick_q) begin
            wdog_d = TW'(0);
        end else begin
            wdog_d = wdog_q + TW'(1);
        end

        case (state_q)
            ST_IDLE: begin
                if (fall_tick_q && !dat_s2_q) begin
                    state_d   = ST_DATA;
                    bit_cnt_d = 3'd0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_DATA: begin
                if (fall_tick_q) begin
                    shift_d   = {dat_s2_q, shift_q[7:1]};
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
                        state_d = ST_PARITY;
                    end else begin
                        state_d = ST_DATA;
                    end
                end else begin
                    state_d = ST_DATA;
                end
            end
            ST_PARITY: begin
                if (fall_tick_q) begin
                    par_d   = dat_s2_q;
                    state_d = ST_STOP;
                end else begin
                    state_d = ST_PARITY;
                end
            end
            ST_STOP: begin
                if (fall_tick_q) begin
                    state_d = ST_IDLE;
                    if (!dat_s2_q) begin
                        frame_err_d = 1'b1;
                    end else if (odd_parity_ok(shift_q, par_q)) begin
                        data_d       = shift_q;
                        data_valid_d = 1'b1;
                    end else begin
                        parity_err_d = 1'b1;
                    end
                end else begin
                    state_d = ST_STOP;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // A real edge in the terminal cycle keeps the frame alive.
        if ((state_q != ST_IDLE) && !fall_tick_q && (wdog_q == TMO_LAST)) begin
            state_d     = ST_IDLE;
            bit_cnt_d   = 3'd0;
            frame_err_d = 1'b1;
            wdog_d      = TW'(0);
        end else begin
            wdog_d = wdog_d;
        end

        busy_d = (state_d != ST_IDLE);
    end

    // All state registers; synchronisers and the filtered clock reset to the idle-high level.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clk_s1_q     <= 1'b1;
            clk_s2_q     <= 1'b1;
            dat_s1_q     <= 1'b1;
            dat_s2_q     <= 1'b1;
            clk_f_q      <= 1'b1;
            flt_cnt_q    <= FW'(0);
            fall_tick_q  <= 1'b0;
            state_q      <= ST_IDLE;
            bit_cnt_q    <= 3'd0;
            shift_q      <= 8'h00;
            par_q        <= 1'b0;
            wdog_q       <= TW'(0);
            data_q       <= 8'h00;
            data_valid_q <= 1'b0;
            parity_err_q <= 1'b0;
            frame_err_q  <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            clk_s1_q     <= clk_s1_d;
            clk_s2_q     <= clk_s2_d;
            dat_s1_q     <= dat_s1_d;
            dat_s2_q     <= dat_s2_d;
            clk_f_q      <= clk_f_d;
            flt_cnt_q    <= flt_cnt_d;
            fall_tick_q  <= fall_tick_d;
            state_q      <= state_d;
            bit_cnt_q    <= bit_cnt_d;
            shift_q      <= shift_d;
            par_q        <= par_d;
            wdog_q       <= wdog_d;
            data_q       <= data_d;
            data_valid_q <= data_valid_d;
            parity_err_q <= parity_err_d;
            frame_err_q  <= frame_err_d;
            busy_q       <= busy_d;
        end
    end

    assign data       = data_q;
    assign data_valid = data_valid_q;
    assign parity_err = parity_err_q;
    assign frame_err  = frame_err_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_ps2_rx_frame.sv
// Bench for ps2_rx_frame: directed PS/2 frames against a frame-level outcome model
// and a per-cycle checker of data and the completion pulses.
module tb_ps2_rx_frame;

    logic       clk;
    logic       rst_n;
    logic       ps2_clk;
    logic       ps2_data;
    logic [7:0] data;
    logic       data_valid;
    logic       parity_err;
    logic       frame_err;
    logic       busy;

    ps2_rx_frame #(.FILTER_LEN(4), .TIMEOUT_CYCLES(200)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .ps2_clk    (ps2_clk),
        .ps2_data   (ps2_data),
        .data       (data),
        .data_valid (data_valid),
        .parity_err (parity_err),
        .frame_err  (frame_err),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef enum logic [1:0] {EV_VALID = 2'd0, EV_PERR = 2'd1, EV_FERR = 2'd2} ev_kind_t;
    typedef struct packed {
        ev_kind_t   kind;
        logic [7:0] byte_v;
    } ev_t;

    ev_t        exp_q[$];
    logic [7:0] model_data;
    int         total = 0;
    int         bad = 0;
    int         cyc = 0;
    int         last_fall_cyc = 0;
    int         ferr_cyc = 0;
    int         pulse_n;
    ev_t        ev;
    ev_kind_t   got_kind;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Frame-level outcome: stop bit checked first, then odd parity over byte plus parity bit.
    function automatic ev_kind_t outcome(input logic [7:0] b, input logic p, input logic s);
        if (s == 1'b0) return EV_FERR;
        if ((($countones(b) + int'(p)) % 2) == 1) return EV_VALID;
        return EV_PERR;
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // Per-cycle checker: pulses are one-hot, match the expected event list, and data tracks the model.
    always @(negedge clk) begin
        if (!rst_n) begin
            model_data = 8'h00;
            exp_q.delete();
        end else begin
            pulse_n = int'(data_valid) + int'(parity_err) + int'(frame_err);
            chk("pulse_onehot", 32'(pulse_n <= 1), 32'd1);
            if (pulse_n >= 1) begin
                if (frame_err) ferr_cyc = cyc;
                if (exp_q.size() == 0) begin
                    chk("unexpected_pulse", {29'd0, data_valid, parity_err, frame_err}, 32'd0);
                end else begin
                    ev = exp_q.pop_front();
                    got_kind = data_valid ? EV_VALID : (parity_err ? EV_PERR : EV_FERR);
                    chk("pulse_kind", 32'(got_kind), 32'(ev.kind));
                    if (ev.kind == EV_VALID) model_data = ev.byte_v;
                    chk("busy_at_done", 32'(busy), 32'd0);
                end
            end
            chk("data_track", 32'(data), 32'(model_data));
        end
    end

    task automatic send_bit(input logic b);
        ps2_data = b;
        repeat (20) @(posedge clk);
        #1 ps2_clk = 1'b0;
        last_fall_cyc = cyc;
        repeat (40) @(posedge clk);
        #1 ps2_clk = 1'b1;
        repeat (20) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] b, input logic p, input logic s);
        exp_q.push_back('{kind: outcome(b, p, s), byte_v: b});
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(b[i]);
        send_bit(p);
        send_bit(s);
        ps2_data = 1'b1;
        repeat (20) @(posedge clk);
        #1 chk("frame_drained", 32'(exp_q.size()), 32'd0);
        chk("busy_idle", 32'(busy), 32'd0);
    endtask

    initial begin
        rst_n    = 1'b0;
        ps2_clk  = 1'b1;
        ps2_data = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        chk("rst_data", 32'(data), 32'h00);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_pulses", {29'd0, data_valid, parity_err, frame_err}, 32'd0);
        rst_n = 1'b1;
        repeat (10) @(posedge clk);
        #1;

        // Model pins against hand-derived outcomes.
        chk("pin_1c", 32'(outcome(8'h1C, 1'b0, 1'b1)), 32'(EV_VALID));
        chk("pin_f0", 32'(outcome(8'hF0, 1'b0, 1'b1)), 32'(EV_PERR));
        chk("pin_45", 32'(outcome(8'h45, 1'b0, 1'b0)), 32'(EV_FERR));

        send_frame(8'h1C, 1'b0, 1'b1);
        chk("lit_data_1c", 32'(data), 32'h1C);
        send_frame(8'hF0, 1'b0, 1'b1);
        chk("lit_data_after_perr", 32'(data), 32'h1C);
        send_frame(8'h45, 1'b0, 1'b0);
        chk("lit_data_after_ferr", 32'(data), 32'h1C);

        // Short glitch with data low: a real tick would start a frame and raise busy.
        ps2_data = 1'b0;
        ps2_clk  = 1'b0;
        repeat (2) @(posedge clk);
        #1 ps2_clk = 1'b1;
        repeat (20) @(posedge clk);
        #1 chk("glitch_busy", 32'(busy), 32'd0);
        ps2_data = 1'b1;
        repeat (20) @(posedge clk);
        #1;

        // Truncated frame: start plus four bits, then the clock stays high.
        send_bit(1'b0);
        chk("busy_mid", 32'(busy), 32'd1);
        for (int i = 0; i < 4; i++) send_bit(1'b1);
        exp_q.push_back('{kind: EV_FERR, byte_v: 8'h00});
        repeat (250) @(posedge clk);
        #1;
        chk("tmo_drained", 32'(exp_q.size()), 32'd0);
        chk("tmo_latency", 32'(((ferr_cyc - last_fall_cyc) >= 200) && ((ferr_cyc - last_fall_cyc) <= 220)), 32'd1);
        chk("tmo_busy", 32'(busy), 32'd0);
        chk("tmo_data", 32'(data), 32'h1C);
        send_frame(8'h16, 1'b0, 1'b1);
        chk("lit_data_16", 32'(data), 32'h16);

        // Reset in the middle of a frame.
        send_bit(1'b0);
        for (int i = 0; i < 5; i++) send_bit(1'b1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_data", 32'(data), 32'h00);
        chk("arst_busy", 32'(busy), 32'd0);
        chk("arst_pulses", {29'd0, data_valid, parity_err, frame_err}, 32'd0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        send_frame(8'h29, 1'b0, 1'b1);
        chk("lit_data_29", 32'(data), 32'h29);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
